// File: rtl/sms_ctrl_card_trio_if.sv
// Card-pin bundle for the AFR / CD / CEYB CTRL card trio.
// master drives the card inputs (system netlist or bench); slave is the card block.
interface sms_ctrl_card_trio_if;
  logic afr_e;
  logic afr_lamp_test;
  logic afr_drive;
  logic afr_lamp;
  logic cd_p;
  logic cd_q;
  logic cd_r;
  logic cd_d;
  logic ceyb_b;
  logic ceyb_f;
  logic ceyb_g;
  logic ceyb_h;

  modport master (
    output afr_e, afr_lamp_test, cd_p, cd_q, cd_r, ceyb_b, ceyb_f,
    input  afr_drive, afr_lamp, cd_d, ceyb_g, ceyb_h
  );

  modport slave (
    input  afr_e, afr_lamp_test, cd_p, cd_q, cd_r, ceyb_b, ceyb_f,
    output afr_drive, afr_lamp, cd_d, ceyb_g, ceyb_h
  );
endinterface

// File: rtl/sms_ctrl_card_trio.sv
// IBM 1620 SMS CTRL cards AFR (lamp driver), CD (3-input inverter) and CEYB (emitter follower).
// Each gate is one clock of latency; the AFR lamp filament is a persistence-filtered OFF/ON machine.
module sms_ctrl_card_trio #(
  parameter int LAMP_ON_DLY  = 4,
  parameter int LAMP_OFF_DLY = 4,
  parameter int CNT_W        = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  sms_ctrl_card_trio_if.slave  card
);

  typedef enum logic {
    LAMP_OFF = 1'b0,
    LAMP_ON  = 1'b1
  } lamp_state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(LAMP_ON_DLY - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(LAMP_OFF_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Undriven or unknown pins read as 0, like the pull-down dot-OR on the backplane.
  function automatic logic pin_level(input logic v);
    return (v === 1'b1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  logic e_p0;
  logic test_p0;
  logic p_p0;
  logic q_p0;
  logic r_p0;
  logic b_p0;
  logic f_p0;

  assign e_p0    = pin_level(card.afr_e);
  assign test_p0 = pin_level(card.afr_lamp_test);
  assign p_p0    = pin_level(card.cd_p);
  assign q_p0    = pin_level(card.cd_q);
  assign r_p0    = pin_level(card.cd_r);
  assign b_p0    = pin_level(card.ceyb_b);
  assign f_p0    = pin_level(card.ceyb_f);

  // ---- p0 -> p1: gate registers (one clock models the transistor delay)
  logic cd_d_p1;
  logic ceyb_g_p1;
  logic ceyb_h_p1;
  logic afr_drive_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_d_p1      <= 1'b0;
      ceyb_g_p1    <= 1'b0;
      ceyb_h_p1    <= 1'b0;
      afr_drive_p1 <= 1'b0;
    end else begin
      cd_d_p1      <= ~(p_p0 & q_p0 & r_p0);
      ceyb_g_p1    <= b_p0 & f_p0;
      ceyb_h_p1    <= f_p0;
      afr_drive_p1 <= e_p0;
    end
  end

  assign card.cd_d      = cd_d_p1;
  assign card.ceyb_g    = ceyb_g_p1;
  assign card.ceyb_h    = ceyb_h_p1;
  assign card.afr_drive = afr_drive_p1;

  // ---- AFR lamp filament: state register
  lamp_state_t      state;
  lamp_state_t      state_nx;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] on_cnt_nx;
  logic [CNT_W-1:0] off_cnt;
  logic [CNT_W-1:0] off_cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LAMP_OFF;
      on_cnt  <= '0;
      off_cnt <= '0;
    end else begin
      state   <= state_nx;
      on_cnt  <= on_cnt_nx;
      off_cnt <= off_cnt_nx;
    end
  end

  // Counters default to 0 so the idle state's counter is always held clear.
  always_comb begin
    state_nx   = state;
    on_cnt_nx  = '0;
    off_cnt_nx = '0;
    if (test_p0) begin
      state_nx = LAMP_ON;
    end else begin
      unique case (state)
        LAMP_OFF: begin
          if (e_p0) begin
            if (on_cnt == ON_LAST) state_nx = LAMP_ON;
            else                   on_cnt_nx = sat_inc(on_cnt);
          end
        end
        LAMP_ON: begin
          if (!e_p0) begin
            if (off_cnt == OFF_LAST) state_nx = LAMP_OFF;
            else                     off_cnt_nx = sat_inc(off_cnt);
          end
        end
        default: state_nx = LAMP_OFF;
      endcase
    end
  end

  assign card.afr_lamp = (state == LAMP_ON);

endmodule

// File: tb/tb_sms_ctrl_card_trio.sv
// Bench for the CTRL card trio: directed steps followed by random stimulus,
// all checked against a run-length lamp model and plain gate equations.
module tb_sms_ctrl_card_trio;
  localparam int DLY = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  sms_ctrl_card_trio_if card_if ();

  sms_ctrl_card_trio #(
    .LAMP_ON_DLY  (DLY),
    .LAMP_OFF_DLY (DLY),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .card  (card_if.slave)
  );

  always #5 clk = ~clk;

  // reference model state
  logic exp_cd, exp_g, exp_h, exp_drive, exp_lamp;
  int   run;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_cd = 0; exp_g = 0; exp_h = 0; exp_drive = 0; exp_lamp = 0; run = 0;
  endtask

  // Lamp changes once the input has disagreed with it for DLY samples in a row.
  task automatic model_edge();
    exp_cd    = !(card_if.cd_p && card_if.cd_q && card_if.cd_r);
    exp_h     = card_if.ceyb_f;
    exp_g     = card_if.ceyb_f && card_if.ceyb_b;
    exp_drive = card_if.afr_e;
    if (card_if.afr_lamp_test) begin
      exp_lamp = 1; run = 0;
    end else if (card_if.afr_e != exp_lamp) begin
      run++;
      if (run == DLY) begin
        exp_lamp = card_if.afr_e; run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".cd_d"},      card_if.cd_d,      exp_cd);
    chk({tag, ".ceyb_g"},    card_if.ceyb_g,    exp_g);
    chk({tag, ".ceyb_h"},    card_if.ceyb_h,    exp_h);
    chk({tag, ".afr_drive"}, card_if.afr_drive, exp_drive);
    chk({tag, ".afr_lamp"},  card_if.afr_lamp,  exp_lamp);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic set_all(input logic e, input logic t, input logic p, input logic q,
                         input logic r, input logic b, input logic f);
    card_if.afr_e = e; card_if.afr_lamp_test = t;
    card_if.cd_p = p; card_if.cd_q = q; card_if.cd_r = r;
    card_if.ceyb_b = b; card_if.ceyb_f = f;
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // reset with every input high except lamp test
    set_all(1, 0, 1, 1, 1, 1, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all("in_reset");
    rst_n = 1'b1;
    tick("first_edge");
    chk("first_edge.cd_d_lit", card_if.cd_d, 1'b0);
    chk("first_edge.g_lit", card_if.ceyb_g, 1'b1);

    // CD truth table
    for (int i = 0; i < 8; i++) begin
      card_if.cd_p = i[2]; card_if.cd_q = i[1]; card_if.cd_r = i[0];
      tick($sformatf("cd_tt%0d", i));
      chk($sformatf("cd_lit%0d", i), card_if.cd_d, (i == 7) ? 1'b0 : 1'b1);
    end

    // CEYB: f=1,b=0 then b tied to f toggling
    card_if.ceyb_f = 1; card_if.ceyb_b = 0;
    tick("ceyb_f1b0");
    for (int i = 0; i < 6; i++) begin
      card_if.ceyb_f = i[0]; card_if.ceyb_b = i[0];
      tick($sformatf("ceyb_tied%0d", i));
    end

    // lamp persistence: clear, 3 high, 4 high, 3-low glitch, 4 low
    card_if.afr_e = 0;
    repeat (DLY) tick("lamp_clear");
    card_if.afr_e = 1; repeat (3) tick("lamp_hi3");
    card_if.afr_e = 0; tick("lamp_hi3_drop");
    chk("lamp_hi3_off", card_if.afr_lamp, 1'b0);
    card_if.afr_e = 1; repeat (4) tick("lamp_hi4");
    chk("lamp_hi4_on", card_if.afr_lamp, 1'b1);
    card_if.afr_e = 0; repeat (3) tick("lamp_glitch");
    card_if.afr_e = 1; tick("lamp_glitch_end");
    chk("lamp_glitch_on", card_if.afr_lamp, 1'b1);
    card_if.afr_e = 0; repeat (4) tick("lamp_lo4");
    chk("lamp_lo4_off", card_if.afr_lamp, 1'b0);

    // lamp test and release
    card_if.afr_lamp_test = 1; tick("ltest_on");
    chk("ltest_forced", card_if.afr_lamp, 1'b1);
    card_if.afr_lamp_test = 0; repeat (4) tick("ltest_rel");
    chk("ltest_rel_off", card_if.afr_lamp, 1'b0);
    card_if.afr_lamp_test = 1; tick("ltest_again");
    async_reset("rst_during_test");
    card_if.afr_lamp_test = 0;
    tick("after_test_rst");

    // async reset mid-filter
    card_if.afr_e = 1; repeat (2) tick("midf_hi2");
    async_reset("midf_rst");
    repeat (3) tick("midf_hi_post");
    chk("midf_still_off", card_if.afr_lamp, 1'b0);
    tick("midf_hi_4th");
    chk("midf_on", card_if.afr_lamp, 1'b1);

    // random stimulus, lamp test rare, e biased into long runs
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) card_if.afr_e = ~card_if.afr_e;
      card_if.afr_lamp_test = ($urandom_range(0, 30) == 0);
      card_if.cd_p = $urandom_range(0, 1); card_if.cd_q = $urandom_range(0, 1);
      card_if.cd_r = $urandom_range(0, 1);
      card_if.ceyb_b = $urandom_range(0, 1); card_if.ceyb_f = $urandom_range(0, 1);
      if ($urandom_range(0, 150) == 0) async_reset("rnd_rst");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sms_ctrl_card_trio.md
Name: sms_ctrl_card_trio

Overview:
- Cycle-based, synthesizable model of three IBM 1620 SMS CTRL card types packaged as one block:
  - AFR: CTRL light driver, N type.
  - CD: CTRL inverter, N type.
  - CEYB: CTRL emitter follower, PNP.
- Card pins are exposed as prefixed ports. The system netlist ties the ports to nets in the same way as the stand-alone cards.
- Gate delay is modelled as one clock of register latency. Lamp filament behaviour is modelled with on/off persistence counters.

Parameters:
- LAMP_ON_DLY, 4, consecutive cycles afr_e must be high before afr_lamp turns on (legal range 1..255).
- LAMP_OFF_DLY, 4, consecutive cycles afr_e must be low before afr_lamp turns off (legal range 1..255).
- CNT_W, 8, width of the persistence counters. It must hold max(LAMP_ON_DLY, LAMP_OFF_DLY).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- afr_e, input, 1, AFR lamp drive input (card pin E), active high.
- afr_lamp_test, input, 1, console lamp test; forces the lamp on.
- afr_drive, output, 1, registered copy of afr_e (lamp driver transistor state).
- afr_lamp, output, 1, lamp illuminated state after persistence filtering.
- cd_p, input, 1, CD pin P.
- cd_q, input, 1, CD pin Q.
- cd_r, input, 1, CD pin R.
- cd_d, output, 1, CD pin D, inverter output.
- ceyb_b, input, 1, CEYB pin B, follower gate input.
- ceyb_f, input, 1, CEYB pin F, follower main input.
- ceyb_g, output, 1, CEYB pin G.
- ceyb_h, output, 1, CEYB pin H.

Behaviour:
- Reset: asserting rst_n low immediately clears all outputs and both counters to 0, with no clock required. This includes cd_d, even though its logic value with low inputs would be 1. Release is synchronous to the next rising edge: outputs reflect inputs starting at the first edge with rst_n high.
- CD:
  - Next-state logic: cd_d <= ~(cd_p & cd_q & cd_r), a 3-input NAND.
  - Latency is 1 cycle from any input change.
- CEYB:
  - Next-state logic: ceyb_h <= ceyb_f; ceyb_g <= ceyb_b & ceyb_f (emitter-follower dot of the two bases).
  - Latency is 1 cycle. Unused pins must be tied low by the integrator. With F high and B tied to F, G follows F.
- AFR drive: afr_drive <= afr_e, with a latency of 1 cycle.
- AFR lamp state machine, states OFF and ON (the state is afr_lamp):
  - OFF: on_cnt increments each cycle afr_e=1 and clears on any cycle afr_e=0. When afr_e=1 and on_cnt == LAMP_ON_DLY-1, go to ON and clear on_cnt. The lamp therefore rises on the LAMP_ON_DLY-th consecutive high sample.
  - ON: off_cnt increments each cycle afr_e=0 and clears on any cycle afr_e=1. When afr_e=0 and off_cnt == LAMP_OFF_DLY-1, go to OFF and clear off_cnt.
  - Counters saturate and never wrap. The counter of the inactive state is held at 0.
- Lamp test:
  - afr_lamp_test=1 forces afr_lamp=1 on the next edge, overriding the filter, and holds both counters at 0.
  - When test is released, the state stays ON and normal OFF filtering resumes from off_cnt=0.
- Simultaneous events: reset dominates lamp test; lamp test dominates afr_e.
- Reset mid-filter: counters are discarded. After release, a full LAMP_ON_DLY run of high samples is again required.
- Unknown or undriven inputs are treated as 0, matching the pull-down dot-OR convention. The implementation must not let X propagate into state.
- No handshake; all paths are free-running.

Test Plan:
- Reset check: hold rst_n=0 with all inputs at 1, then deassert. All outputs read 0 during reset. On the first edge afterwards: cd_d=0, ceyb_g=1, ceyb_h=1, afr_drive=1, afr_lamp=0.
- CD truth table: sweep p,q,r through all 8 combinations. cd_d=0 only for p=q=r=1, else 1, each appearing one cycle after the input is applied.
- CEYB: with f=1 and b=0, expect h=1 and g=0. With b tied to f and f toggling, g and h follow f with a 1-cycle lag.
- Lamp persistence (defaults of 4): afr_e high for 3 cycles then low keeps afr_lamp=0. Afr_e high for 4 cycles gives afr_lamp=1 on the 4th edge. A 3-cycle low glitch keeps the lamp on. Afr_e low for 4 cycles gives afr_lamp=0.
- Lamp test and override: afr_lamp_test=1 with afr_e=0 gives afr_lamp=1 on the next edge. Releasing test gives afr_lamp=0 after 4 low cycles. Asserting rst_n=0 while test=1 immediately forces the lamp to 0.
- Async reset mid-filter: afr_e high for 2 cycles, pulse rst_n low between edges, then drive afr_e high again. The lamp needs 4 more high cycles after release.
